// File: rtl/metal_blade_ctrl.sv
// Boss projectile controller: latches an aimed blade on fire, moves it once per
// video frame, retires it off-screen / on player hit / on timeout, then cools down.
module metal_blade_ctrl #(
   parameter int SCREEN_W   = 640,
   parameter int SCREEN_H   = 480,
   parameter int BLADE_SIZE = 8,
   parameter int HIT_RADIUS = 8,
   parameter int COOLDOWN   = 30,
   parameter int MAX_FLIGHT = 255
) (
   input  logic       Clk,
   input  logic       Reset,
   input  logic       frame_clk_rising,
   input  logic       fire,
   input  logic [9:0] metalmanX,
   input  logic [9:0] metalmanY,
   input  logic [9:0] xvel_in,
   input  logic [9:0] yvel_in,
   input  logic [9:0] charX,
   input  logic [9:0] charY,
   output logic [9:0] bladeX,
   output logic [9:0] bladeY,
   output logic       blade_active,
   output logic       ready,
   output logic       hit
);

   localparam int FW = $clog2(MAX_FLIGHT + 1);
   localparam int CW = $clog2(COOLDOWN + 1);
   localparam logic [FW-1:0]     FLIGHT_MAX = FW'(MAX_FLIGHT);
   localparam logic [CW-1:0]     COOL_LOAD  = CW'(COOLDOWN);
   localparam logic signed [11:0] XMAX      = 12'(SCREEN_W - BLADE_SIZE);
   localparam logic signed [11:0] YMAX      = 12'(SCREEN_H - BLADE_SIZE);
   localparam logic [12:0]        HIT_R     = 13'(HIT_RADIUS);

   typedef enum logic [1:0] {IDLE, FLY, COOL} state_t;

   state_t             state_q, state_d;
   logic [9:0]         x_q, x_d, y_q, y_d;
   logic signed [9:0]  vx_q, vy_q;
   logic [FW-1:0]      flight_q, flight_d, flight_inc;
   logic [CW-1:0]      cool_q, cool_d;
   logic               active_q, active_d;
   logic               ready_q, ready_d;
   logic               hit_q, hit_d;
   logic               latch;
   logic signed [11:0] nx, ny;
   logic               off_screen, hit_test;

   // Magnitude of (signed candidate position - unsigned player coordinate), no 10-bit wrap.
   function automatic logic [12:0] abs_diff(input logic signed [11:0] a, input logic [9:0] b);
      logic signed [12:0] d;
      d = {a[11], a} - {3'b000, b};
      return d[12] ? -d : d;
   endfunction

   assign nx = $signed({2'b00, x_q}) + $signed({{2{vx_q[9]}}, vx_q});
   assign ny = $signed({2'b00, y_q}) + $signed({{2{vy_q[9]}}, vy_q});
   assign off_screen = (nx < 12'sd0) || (nx > XMAX) || (ny < 12'sd0) || (ny > YMAX);
   assign hit_test   = (abs_diff(nx, charX) < HIT_R) && (abs_diff(ny, charY) < HIT_R);
   assign flight_inc = flight_q + FW'(1);

   always_comb begin
      state_d  = state_q;
      x_d      = x_q;
      y_d      = y_q;
      flight_d = flight_q;
      cool_d   = cool_q;
      active_d = active_q;
      hit_d    = 1'b0;
      latch    = 1'b0;
      unique case (state_q)
         IDLE: begin
            // A fire wins over a coincident frame tick: the blade only appears this cycle.
            if (fire) begin
               latch    = 1'b1;
               x_d      = metalmanX;
               y_d      = metalmanY;
               flight_d = '0;
               active_d = 1'b1;
               state_d  = FLY;
            end
         end
         FLY: begin
            if (frame_clk_rising) begin
               if (off_screen) begin
                  active_d = 1'b0;
                  cool_d   = COOL_LOAD;
                  state_d  = COOL;
               end else begin
                  x_d      = nx[9:0];
                  y_d      = ny[9:0];
                  flight_d = flight_inc;
                  if (hit_test) begin
                     hit_d    = 1'b1;
                     active_d = 1'b0;
                     cool_d   = COOL_LOAD;
                     state_d  = COOL;
                  end else if (flight_inc == FLIGHT_MAX) begin
                     active_d = 1'b0;
                     cool_d   = COOL_LOAD;
                     state_d  = COOL;
                  end
               end
            end
         end
         COOL: begin
            if (frame_clk_rising) begin
               cool_d = cool_q - CW'(1);
               if (cool_d == '0) state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
      ready_d = (state_d == IDLE);
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q  <= IDLE;
         x_q      <= '0;
         y_q      <= '0;
         flight_q <= '0;
         cool_q   <= '0;
         active_q <= 1'b0;
         ready_q  <= 1'b1;
         hit_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         x_q      <= x_d;
         y_q      <= y_d;
         flight_q <= flight_d;
         cool_q   <= cool_d;
         active_q <= active_d;
         ready_q  <= ready_d;
         hit_q    <= hit_d;
      end
   end

   // Velocity is pure data; it is only meaningful while FLY, which reset never leaves us in.
   always_ff @(posedge Clk) begin
      if (latch) begin
         vx_q <= $signed(xvel_in);
         vy_q <= $signed(yvel_in);
      end
   end

   assign bladeX       = x_q;
   assign bladeY       = y_q;
   assign blade_active = active_q;
   assign ready        = ready_q;
   assign hit          = hit_q;

endmodule

// File: tb/tb_metal_blade_ctrl.sv
// Bench for metal_blade_ctrl: per-cycle comparison against a behavioural model,
// plus directed scenarios with literal expectations.
module tb_metal_blade_ctrl;

   logic       Clk = 1'b0;
   logic       Reset, frame_clk_rising, fire;
   logic [9:0] metalmanX, metalmanY, xvel_in, yvel_in, charX, charY;
   logic [9:0] bladeX, bladeY;
   logic       blade_active, ready, hit;

   int nchk  = 0;
   int nfail = 0;

   localparam int P_IDLE = 0, P_FLY = 1, P_COOL = 2;
   int m_phase, m_x, m_y, m_vx, m_vy, m_fc, m_cd, m_nx, m_ny, m_dx, m_dy;
   bit m_act, m_rdy, m_hit;
   bit m_valid = 1'b0;

   always #5 Clk = ~Clk;

   metal_blade_ctrl dut (
      .Clk(Clk), .Reset(Reset), .frame_clk_rising(frame_clk_rising), .fire(fire),
      .metalmanX(metalmanX), .metalmanY(metalmanY), .xvel_in(xvel_in), .yvel_in(yvel_in),
      .charX(charX), .charY(charY), .bladeX(bladeX), .bladeY(bladeY),
      .blade_active(blade_active), .ready(ready), .hit(hit)
   );

   task automatic check(input string name, input int act, input int exp);
      nchk++;
      if (act != exp) begin
         nfail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Behavioural model: what each output must be after every clock edge.
   always @(posedge Clk) begin
      if (Reset) begin
         m_phase = P_IDLE; m_x = 0; m_y = 0; m_act = 0; m_hit = 0; m_rdy = 1;
         m_fc = 0; m_cd = 0; m_valid = 1'b1;
      end else if (m_valid) begin
         m_hit = 0;
         if (m_phase == P_IDLE) begin
            if (fire) begin
               m_x = int'(metalmanX); m_y = int'(metalmanY);
               m_vx = int'($signed(xvel_in)); m_vy = int'($signed(yvel_in));
               m_fc = 0; m_act = 1; m_phase = P_FLY;
            end
         end else if (m_phase == P_FLY) begin
            if (frame_clk_rising) begin
               m_nx = m_x + m_vx;
               m_ny = m_y + m_vy;
               if (m_nx < 0 || m_nx > 640 - 8 || m_ny < 0 || m_ny > 480 - 8) begin
                  m_act = 0; m_cd = 30; m_phase = P_COOL;
               end else begin
                  m_x = m_nx; m_y = m_ny; m_fc = m_fc + 1;
                  m_dx = m_nx - int'(charX); if (m_dx < 0) m_dx = -m_dx;
                  m_dy = m_ny - int'(charY); if (m_dy < 0) m_dy = -m_dy;
                  if (m_dx < 8 && m_dy < 8) begin
                     m_hit = 1; m_act = 0; m_cd = 30; m_phase = P_COOL;
                  end else if (m_fc == 255) begin
                     m_act = 0; m_cd = 30; m_phase = P_COOL;
                  end
               end
            end
         end else begin
            if (frame_clk_rising) begin
               m_cd = m_cd - 1;
               if (m_cd == 0) m_phase = P_IDLE;
            end
         end
         m_rdy = (m_phase == P_IDLE);
      end
   end

   always @(negedge Clk) begin
      if (m_valid) begin
         check("model_bladeX", int'(bladeX), m_x);
         check("model_bladeY", int'(bladeY), m_y);
         check("model_active", int'(blade_active), int'(m_act));
         check("model_ready", int'(ready), int'(m_rdy));
         check("model_hit", int'(hit), int'(m_hit));
      end
   end

   task automatic cyc(input int n);
      repeat (n) @(negedge Clk);
   endtask

   task automatic tick();
      @(negedge Clk);
      frame_clk_rising = 1'b1;
      @(negedge Clk);
      frame_clk_rising = 1'b0;
   endtask

   task automatic launch(input int bx, input int by, input int vx, input int vy);
      metalmanX = 10'(bx); metalmanY = 10'(by);
      xvel_in = 10'(vx); yvel_in = 10'(vy);
      fire = 1'b1;
      @(negedge Clk);
      fire = 1'b0;
   endtask

   task automatic wait_ready(input int bound);
      int k = 0;
      while (!ready && k < bound) begin
         tick();
         k++;
      end
      check("wait_ready", int'(ready), 1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish at %0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      Reset = 1'b1; frame_clk_rising = 1'b0; fire = 1'b0;
      metalmanX = '0; metalmanY = '0; xvel_in = '0; yvel_in = '0;
      charX = 10'd0; charY = 10'd0;
      cyc(2);
      Reset = 1'b0;
      check("rst_ready", int'(ready), 1);
      check("rst_active", int'(blade_active), 0);
      check("rst_bladeX", int'(bladeX), 0);
      check("rst_hit", int'(hit), 0);

      // 1: straight flight
      launch(300, 100, 4, 2);
      check("t1_active", int'(blade_active), 1);
      check("t1_ready", int'(ready), 0);
      check("t1_latchX", int'(bladeX), 300);
      repeat (3) tick();
      check("t1_X", int'(bladeX), 312);
      check("t1_Y", int'(bladeY), 106);
      check("t1_active3", int'(blade_active), 1);
      Reset = 1'b1; cyc(1); Reset = 1'b0;

      // 2: leave left edge, then full cooldown
      charX = 10'd400; charY = 10'd400;
      launch(10, 100, -4, 0);
      tick(); check("t2_X1", int'(bladeX), 6);
      tick(); check("t2_X2", int'(bladeX), 2);
      tick();
      check("t2_off_active", int'(blade_active), 0);
      check("t2_off_X", int'(bladeX), 2);
      check("t2_off_ready", int'(ready), 0);
      repeat (29) tick();
      check("t2_cool29_ready", int'(ready), 0);
      tick();
      check("t2_cool30_ready", int'(ready), 1);

      // 3: player hit on the second tick
      charX = 10'd112; charY = 10'd100;
      launch(100, 100, 3, 0);
      tick();
      check("t3_X1", int'(bladeX), 103);
      check("t3_hit1", int'(hit), 0);
      tick();
      check("t3_X2", int'(bladeX), 106);
      check("t3_hit2", int'(hit), 1);
      check("t3_active", int'(blade_active), 0);
      cyc(1);
      check("t3_hit_gone", int'(hit), 0);
      wait_ready(40);

      // 4: zero velocity times out on the 255th tick
      charX = 10'd600; charY = 10'd400;
      launch(200, 200, 0, 0);
      repeat (254) tick();
      check("t4_active254", int'(blade_active), 1);
      check("t4_X254", int'(bladeX), 200);
      check("t4_Y254", int'(bladeY), 200);
      tick();
      check("t4_active255", int'(blade_active), 0);
      check("t4_ready255", int'(ready), 0);
      wait_ready(40);

      // 5: fire held through FLY and COOL
      metalmanX = 10'd300; metalmanY = 10'd100;
      xvel_in = 10'd0; yvel_in = 10'(-4);
      fire = 1'b1;
      @(negedge Clk);
      check("t5_active", int'(blade_active), 1);
      repeat (26) tick();
      check("t5_off_active", int'(blade_active), 0);
      check("t5_off_Y", int'(bladeY), 0);
      repeat (29) tick();
      check("t5_cool_ready", int'(ready), 0);
      check("t5_cool_active", int'(blade_active), 0);
      tick();
      check("t5_ready", int'(ready), 1);
      @(negedge Clk);
      check("t5_relaunch_active", int'(blade_active), 1);
      check("t5_relaunch_Y", int'(bladeY), 100);
      check("t5_relaunch_ready", int'(ready), 0);
      fire = 1'b0;

      // 6: reset on a frame tick that would otherwise hit
      charX = 10'd300; charY = 10'd100;
      @(negedge Clk);
      Reset = 1'b1; frame_clk_rising = 1'b1;
      @(negedge Clk);
      Reset = 1'b0; frame_clk_rising = 1'b0;
      check("t6_X", int'(bladeX), 0);
      check("t6_Y", int'(bladeY), 0);
      check("t6_active", int'(blade_active), 0);
      check("t6_hit", int'(hit), 0);
      check("t6_ready", int'(ready), 1);
      cyc(1);
      check("t6_hit_after", int'(hit), 0);
      launch(50, 60, 1, 1);
      check("t6_launch_active", int'(blade_active), 1);
      check("t6_launch_X", int'(bladeX), 50);
      tick();
      check("t6_move_X", int'(bladeX), 51);
      check("t6_move_Y", int'(bladeY), 61);

      cyc(2);
      $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
      $finish;
   end

endmodule
